// File: rtl/bus_pkg.sv
// Shared constants for the wait-state bus slaves: response codes, FSM state encoding
// and the decoder window selects.
package bus_pkg;

    typedef logic [1:0] resp_t;
    typedef logic [2:0] state_t;

    localparam resp_t RESP_OKAY  = 2'b00;
    localparam resp_t RESP_ERROR = 2'b01;
    localparam resp_t RESP_RETRY = 2'b10;
    localparam resp_t RESP_SPLIT = 2'b11;

    localparam state_t IDLE = 3'd0;
    localparam state_t WAIT = 3'd1;
    localparam state_t DONE = 3'd2;
    localparam state_t ERR1 = 3'd3;
    localparam state_t ERR2 = 3'd4;
    localparam state_t SPL1 = 3'd5;
    localparam state_t SPL2 = 3'd6;
    localparam state_t BG   = 3'd7;

    // Value of addr[15:13] that each slave window answers.
    localparam logic [2:0] SEL_SLAVE0 = 3'b000;
    localparam logic [2:0] SEL_SLAVE1 = 3'b001;
    localparam logic [2:0] SEL_SLAVE2 = 3'b010;
    localparam logic [2:0] SEL_SLAVE3 = 3'b011;

    // States in which the slave holds the bus with rdy low.
    function automatic logic state_stalls(input state_t st);
        return (st == WAIT) || (st == ERR1) || (st == SPL1);
    endfunction

endpackage

// File: rtl/slave_mem_array.sv
// Single-port word RAM: synchronous write, asynchronous read, MEM_DEPTH x DATA_W.
module slave_mem_array #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/bus_slave_mem.sv
// Wait-state bus slave backed by a local word memory.
// Optional split-transfer support is compiled in with `define SLAVE_SPLIT_EN.
module bus_slave_mem
    import bus_pkg::*;
#(
    parameter int         DATA_W      = 32,
    parameter int         ADDR_W      = 16,
    parameter logic [2:0] SLAVE_SEL   = SEL_SLAVE1,
    parameter int         MEM_DEPTH   = 256,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              trans_valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic              read_write,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdy,
    output logic [1:0]        resp,
    output logic              split_done,
    output state_t            state_dbg
);

    // Handshake: a request (sel & trans_valid & window hit) is taken on a rising edge
    // only while rdy = 1; the transfer then completes on the first later edge with
    // rdy = 1, and wdata must stay stable until that edge.

    localparam int          OFF_W   = ADDR_W - 3;
    localparam int          IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
    localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  off_q;
    logic              rw_q;
    resp_t             err_code_q;
    logic [DATA_W-1:0] rdata_q;

    logic              req;
    logic              in_range;
    logic              can_accept;
    logic              accept;
    logic              busy_eff;
    logic              pend_eff;
    logic [IDX_W-1:0]  req_idx;
    state_t            acc_state;
    state_t            home_state;
    resp_t             acc_code;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] done_rdata;

`ifdef SLAVE_SPLIT_EN
    logic              bg_busy;
    logic              bg_fire;
    logic [3:0]        bg_cnt;
    logic              split_ready;
    logic              split_done_q;
    logic [IDX_W-1:0]  sp_idx;
    logic              sp_rw;
    logic [DATA_W-1:0] hold_q;
    logic              from_split;
    logic              acc_split_hit;

    // SPL2 counts as busy so a request on its closing edge is retried, not split again.
    assign busy_eff = bg_busy || (state == SPL2);
    assign pend_eff = split_ready && !((state == DONE) && from_split);
    assign bg_fire  = bg_busy && (bg_cnt == 4'd1);
`else
    assign busy_eff = 1'b0;
    assign pend_eff = 1'b0;
`endif

    assign req        = sel & trans_valid & (addr[ADDR_W-1:ADDR_W-3] == SLAVE_SEL);
    assign req_idx    = addr[IDX_W-1:0];
    assign in_range   = {{(32-OFF_W){1'b0}}, addr[OFF_W-1:0]} < DEPTH_U;
    assign can_accept = (state == IDLE) || (state == BG) || (state == DONE) ||
                        (state == ERR2) || (state == SPL2);
    assign accept     = req && can_accept;
    assign home_state = (busy_eff || pend_eff) ? BG : IDLE;

    // Where a freshly sampled request goes; range errors win over everything else.
    always_comb begin
        acc_state = NO_WAIT ? DONE : WAIT;
        acc_code  = RESP_ERROR;
`ifdef SLAVE_SPLIT_EN
        acc_split_hit = 1'b0;
`endif
        if (!in_range) begin
            acc_state = ERR1;
`ifdef SLAVE_SPLIT_EN
        end else if (pend_eff && (req_idx == sp_idx) && (read_write == sp_rw)) begin
            acc_state     = DONE;
            acc_split_hit = 1'b1;
        end else if (busy_eff || pend_eff) begin
            acc_state = ERR1;
            acc_code  = RESP_RETRY;
        end else if (WAIT_CYCLES >= 4) begin
            acc_state = SPL1;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, BG, DONE, ERR2, SPL2: state_nxt = accept ? acc_state : home_state;
            WAIT:    if (cnt == 4'd1) state_nxt = DONE;
            ERR1:    state_nxt = ERR2;
            SPL1:    state_nxt = SPL2;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            off_q      <= '0;
            rw_q       <= 1'b0;
            err_code_q <= RESP_ERROR;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (accept) begin
                off_q      <= req_idx;
                rw_q       <= read_write;
                cnt        <= WAIT_LD;
                err_code_q <= acc_code;
            end
            if ((state == DONE) && !rw_q) begin
                rdata_q <= done_rdata;
            end
        end
    end

`ifdef SLAVE_SPLIT_EN
    // Background engine: runs the split transfer while the bus side keeps answering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bg_busy      <= 1'b0;
            bg_cnt       <= 4'd0;
            split_ready  <= 1'b0;
            split_done_q <= 1'b0;
            sp_idx       <= '0;
            sp_rw        <= 1'b0;
            hold_q       <= '0;
            from_split   <= 1'b0;
        end else begin
            split_done_q <= 1'b0;
            if (accept) begin
                from_split <= acc_split_hit;
            end
            if (state == SPL2) begin
                bg_busy <= 1'b1;
                bg_cnt  <= WAIT_LD;
                sp_idx  <= off_q;
                sp_rw   <= rw_q;
                if (rw_q) begin
                    hold_q <= wdata;
                end
            end else if (bg_fire) begin
                bg_busy      <= 1'b0;
                split_ready  <= 1'b1;
                split_done_q <= 1'b1;
                if (!sp_rw) begin
                    hold_q <= mem_rdata;
                end
            end else if (bg_busy) begin
                bg_cnt <= bg_cnt - 4'd1;
            end
            if ((state == DONE) && from_split) begin
                split_ready <= 1'b0;
            end
        end
    end

    assign mem_we     = rst && (((state == DONE) && rw_q && !from_split) || (bg_fire && sp_rw));
    assign mem_addr   = bg_fire ? sp_idx : off_q;
    assign mem_wdata  = bg_fire ? hold_q : wdata;
    assign done_rdata = from_split ? hold_q : mem_rdata;
    assign split_done = split_done_q;
`else
    assign mem_we     = rst && (state == DONE) && rw_q;
    assign mem_addr   = off_q;
    assign mem_wdata  = wdata;
    assign done_rdata = mem_rdata;
    assign split_done = 1'b0;
`endif

    slave_mem_array #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign rdy = !state_stalls(state);

    always_comb begin
        case (state)
            ERR1, ERR2: resp = err_code_q;
            SPL1, SPL2: resp = RESP_SPLIT;
            default:    resp = RESP_OKAY;
        endcase
    end

    // A completing read shows memory data directly; otherwise the last read is held.
    assign rdata     = ((state == DONE) && !rw_q) ? done_rdata : rdata_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Cycle-accurate scoreboard bench for bus_slave_mem; split scenarios run when
// SLAVE_SPLIT_EN is defined.
module tb_bus_slave_mem;
    import bus_pkg::*;

`ifdef SLAVE_SPLIT_EN
    localparam int WC = 5;
`else
    localparam int WC = 2;
`endif

    logic        clk;
    logic        rst;
    logic        sel;
    logic        trans_valid;
    logic [15:0] addr;
    logic        read_write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdy;
    logic [1:0]  resp;
    logic        split_done;
    state_t      state_dbg;

    // Expected outputs for one cycle: {rdy, resp, split_done, rdata}.
    logic [35:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    int          cyc;
    string       tag;
    logic [31:0] prev;
    logic [31:0] cur_wd;

    bus_slave_mem #(
        .DATA_W      (32),
        .ADDR_W      (16),
        .SLAVE_SEL   (3'b001),
        .MEM_DEPTH   (256),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .trans_valid (trans_valid),
        .addr        (addr),
        .read_write  (read_write),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdy         (rdy),
        .resp        (resp),
        .split_done  (split_done),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    function automatic logic [35:0] ex(input logic r, input logic [1:0] rs, input logic sd,
                                       input logic [31:0] d);
        return {r, rs, sd, d};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s [%s] cyc=%0d state=%0d got=%0h want=%0h",
                     nm, tag, cyc, state_dbg, got, want);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [35:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rdy", {31'd0, rdy}, {31'd0, e[35]});
            chk("resp", {30'd0, resp}, {30'd0, e[34:33]});
            chk("split_done", {31'd0, split_done}, {31'd0, e[32]});
            chk("rdata", rdata, e[31:0]);
        end
    end

    // driver tasks: set inputs sampled at the next edge, queue this cycle's expected outputs
    task automatic step(input logic s, input logic tv, input logic [15:0] a, input logic rw,
                        input logic [31:0] wd, input logic [35:0] e);
        sel         = s;
        trans_valid = tv;
        addr        = a;
        read_write  = rw;
        wdata       = wd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [35:0] e);
        step(1'b0, 1'b0, 16'h0000, 1'b0, cur_wd, e);
    endtask

    task automatic xfer_wait(input logic [15:0] a, input logic rw, input logic [31:0] wd,
                             input logic [31:0] rd_exp);
        cur_wd = wd;
        step(1'b1, 1'b1, a, rw, wd, ex(1'b1, RESP_OKAY, 1'b0, prev));
        for (int i = 0; i < WC; i++) idle(ex(1'b0, RESP_OKAY, 1'b0, prev));
        if (!rw) prev = rd_exp;
        idle(ex(1'b1, RESP_OKAY, 1'b0, prev));
    endtask

    task automatic xfer_split(input logic [15:0] a, input logic rw, input logic [31:0] wd,
                              input logic [31:0] rd_exp);
        cur_wd = wd;
        step(1'b1, 1'b1, a, rw, wd, ex(1'b1, RESP_OKAY, 1'b0, prev));
        idle(ex(1'b0, RESP_SPLIT, 1'b0, prev));
        idle(ex(1'b1, RESP_SPLIT, 1'b0, prev));
        idle(ex(1'b1, RESP_OKAY, 1'b0, prev));
        step(1'b1, 1'b1, 16'h2010, 1'b0, wd, ex(1'b1, RESP_OKAY, 1'b0, prev));
        idle(ex(1'b0, RESP_RETRY, 1'b0, prev));
        idle(ex(1'b1, RESP_RETRY, 1'b0, prev));
        idle(ex(1'b1, RESP_OKAY, 1'b0, prev));
        step(1'b1, 1'b1, a, rw, wd, ex(1'b1, RESP_OKAY, 1'b1, prev));
        if (!rw) prev = rd_exp;
        idle(ex(1'b1, RESP_OKAY, 1'b0, prev));
    endtask

    task automatic xfer(input logic [15:0] a, input logic rw, input logic [31:0] wd,
                        input logic [31:0] rd_exp);
`ifdef SLAVE_SPLIT_EN
        xfer_split(a, rw, wd, rd_exp);
`else
        xfer_wait(a, rw, wd, rd_exp);
`endif
    endtask

    task automatic xfer_err(input logic [15:0] a, input logic rw, input logic [31:0] wd);
        cur_wd = wd;
        step(1'b1, 1'b1, a, rw, wd, ex(1'b1, RESP_OKAY, 1'b0, prev));
        idle(ex(1'b0, RESP_ERROR, 1'b0, prev));
        idle(ex(1'b1, RESP_ERROR, 1'b0, prev));
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; prev = 32'd0; cur_wd = 32'd0;
        rst = 1'b0; sel = 1'b0; trans_valid = 1'b0; addr = 16'h0; read_write = 1'b0;
        wdata = 32'd0; tag = "reset";
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(ex(1'b1, RESP_OKAY, 1'b0, 32'd0));
        idle(ex(1'b1, RESP_OKAY, 1'b0, 32'd0));

        tag = "write_read";
        xfer(16'h2008, 1'b1, 32'd567, 32'd0);
        xfer(16'h2008, 1'b0, 32'd0, 32'd567);

        tag = "range_error";
        xfer_err(16'h2108, 1'b0, 32'd0);
        xfer_err(16'h2108, 1'b1, 32'd999);
        xfer(16'h2008, 1'b0, 32'd0, 32'd567);

        tag = "boundary";
        xfer_err(16'h2100, 1'b0, 32'd0);
        xfer(16'h20FF, 1'b1, 32'hA5A5_0F0F, 32'd0);
        xfer(16'h20FF, 1'b0, 32'd0, 32'hA5A5_0F0F);

        tag = "no_select";
        step(1'b1, 1'b1, 16'h4008, 1'b0, cur_wd, ex(1'b1, RESP_OKAY, 1'b0, prev));
        step(1'b0, 1'b1, 16'h2008, 1'b0, cur_wd, ex(1'b1, RESP_OKAY, 1'b0, prev));
        step(1'b1, 1'b0, 16'h2008, 1'b0, cur_wd, ex(1'b1, RESP_OKAY, 1'b0, prev));
        idle(ex(1'b1, RESP_OKAY, 1'b0, prev));

`ifndef SLAVE_SPLIT_EN
        tag = "back_to_back";
        cur_wd = 32'd50;
        step(1'b1, 1'b1, 16'h2001, 1'b1, 32'd50, ex(1'b1, RESP_OKAY, 1'b0, prev));
        for (int i = 0; i < WC; i++) idle(ex(1'b0, RESP_OKAY, 1'b0, prev));
        step(1'b1, 1'b1, 16'h2001, 1'b0, 32'd50, ex(1'b1, RESP_OKAY, 1'b0, prev));
        for (int i = 0; i < WC; i++) idle(ex(1'b0, RESP_OKAY, 1'b0, prev));
        prev = 32'd50;
        idle(ex(1'b1, RESP_OKAY, 1'b0, prev));

        tag = "reset_mid_wait";
        cur_wd = 32'd777;
        step(1'b1, 1'b1, 16'h2008, 1'b1, 32'd777, ex(1'b1, RESP_OKAY, 1'b0, prev));
        rst = 1'b0;
        idle(ex(1'b0, RESP_OKAY, 1'b0, prev));
        rst = 1'b1;
        prev = 32'd0;
        idle(ex(1'b1, RESP_OKAY, 1'b0, prev));
        xfer(16'h2008, 1'b0, 32'd0, 32'd567);
`endif

        tag = "end";
        idle(ex(1'b1, RESP_OKAY, 1'b0, prev));
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
